matvec_sched: RTL and testbench

Sequencer that time-shares one `array_prod` dot-product unit to compute a full matrix-vector product of NUM_ROWS rows by HIDDEN_SZ columns in QN.QM fixed point. It captures an input vector on `start` and fetches one weight row per pass from a synchronous weight memory. For each row it releases `array_prod` from reset, waits for its `dataReady`, and stores the result into a packed output vector. It sits between the layer-level control and the `array_prod` instance, and drives that instance's `reset` pin as the per-row start/clear.

---
 rtl/matvec_sched_if.sv | 36 +++
 rtl/matvec_sched.sv | 150 +++++++++++++++
 tb/tb_matvec_sched.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/matvec_sched_if.sv
// matvec_sched_if
// Bundles every non-clock/reset signal of matvec_sched: the layer-level
// start/inVec handshake, the weight memory read port, the array_prod
// connection and the result/status outputs.
//   master : environment side (layer control, weight memory, array_prod)
//   slave  : matvec_sched side
interface matvec_sched_if #(
  parameter int NUM_ROWS          = 8,
  parameter int HIDDEN_SZ         = 8,
  parameter int BITWIDTH          = 18,
  parameter int ROW_ADDR_BITWIDTH = 3
);
  logic                            start;
  logic [BITWIDTH*HIDDEN_SZ-1:0]   inVec;
  logic [ROW_ADDR_BITWIDTH-1:0]    rowAddr;
  logic [BITWIDTH*HIDDEN_SZ-1:0]   weightRow;
  logic [BITWIDTH*HIDDEN_SZ-1:0]   prodWeight;
  logic [BITWIDTH*HIDDEN_SZ-1:0]   prodVec;
  logic                            prodReset;
  logic                            prodReady;
  logic [BITWIDTH-1:0]             prodResult;
  logic [BITWIDTH*NUM_ROWS-1:0]    outVec;
  logic                            busy;
  logic                            done;
  logic                            error;

  modport master (
    output start, inVec, weightRow, prodReady, prodResult,
    input  rowAddr, prodWeight, prodVec, prodReset, outVec, busy, done, error
  );

  modport slave (
    input  start, inVec, weightRow, prodReady, prodResult,
    output rowAddr, prodWeight, prodVec, prodReset, outVec, busy, done, error
  );
endinterface

// File: rtl/matvec_sched.sv
// matvec_sched
// Time-shares one array_prod dot-product unit over NUM_ROWS weight rows to
// build a full matrix-vector product. The input vector is captured on start,
// each weight row is fetched from a 1-cycle-latency synchronous memory, and
// array_prod is held in reset (prodReset=1) everywhere except RUN so it is
// cleared between rows. Each row's result is copied bit-exact into outVec.
// Ports:
//   clock  : system clock, rising edge
//   reset  : synchronous active-high reset
//   bus    : matvec_sched_if.slave (start/inVec, rowAddr/weightRow,
//            prodWeight/prodVec/prodReset/prodReady/prodResult,
//            outVec, busy, done, error)
//
// state | meaning
// IDLE  | waiting for start; inputs captured on accept
// FETCH | rowAddr presented to the weight memory
// LOAD  | memory data registered into prodWeight, watchdog cleared
// RUN   | array_prod released; waiting for prodReady or watchdog expiry
// STORE | held result written into outVec slot rowIdx
// DONE  | one-cycle done pulse
module matvec_sched #(
  parameter int NUM_ROWS          = 8,
  parameter int HIDDEN_SZ         = 8,
  parameter int QN                = 6,
  parameter int QM                = 11,
  parameter int ROW_ADDR_BITWIDTH = 3,
  parameter int TIMEOUT           = 64
) (
  input logic          clock,
  input logic          reset,
  matvec_sched_if.slave bus
);
  localparam int BITWIDTH = QN + QM + 1;
  localparam int VEC_W    = BITWIDTH * HIDDEN_SZ;
  localparam int OUT_W    = BITWIDTH * NUM_ROWS;
  localparam int WD_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [WD_W-1:0]              WD_LAST  = WD_W'(TIMEOUT - 1);
  localparam logic [ROW_ADDR_BITWIDTH-1:0] ROW_LAST = ROW_ADDR_BITWIDTH'(NUM_ROWS - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    RUN,
    STORE,
    DONE
  } stateT;

  stateT                        state;
  logic [ROW_ADDR_BITWIDTH-1:0] rowIdx;
  logic [ROW_ADDR_BITWIDTH-1:0] rowAddr;
  logic [VEC_W-1:0]             prodWeight;
  logic [VEC_W-1:0]             prodVec;
  logic [OUT_W-1:0]             outVec;
  logic [BITWIDTH-1:0]          resultHold;
  logic [WD_W-1:0]              wdCnt;
  logic                         prodReset;
  logic                         busy;
  logic                         done;
  logic                         error;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      rowIdx     <= '0;
      rowAddr    <= '0;
      prodWeight <= '0;
      prodVec    <= '0;
      outVec     <= '0;
      resultHold <= '0;
      wdCnt      <= '0;
      prodReset  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            prodVec <= bus.inVec;
            rowIdx  <= '0;
            rowAddr <= '0;
            error   <= 1'b0;
            busy    <= 1'b1;
            state   <= FETCH;
          end
        end
        FETCH: begin
          state <= LOAD;
        end
        LOAD: begin
          prodWeight <= bus.weightRow;
          wdCnt      <= '0;
          prodReset  <= 1'b0;
          state      <= RUN;
        end
        RUN: begin
          // The result is captured here so prodResult is never looked at
          // once array_prod goes back into reset.
          if (bus.prodReady) begin
            resultHold <= bus.prodResult;
            prodReset  <= 1'b1;
            state      <= STORE;
          end else if (wdCnt == WD_LAST) begin
            error     <= 1'b1;
            prodReset <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            wdCnt <= wdCnt + 1'b1;
          end
        end
        STORE: begin
          for (int r = 0; r < NUM_ROWS; r++) begin
            if (rowIdx == ROW_ADDR_BITWIDTH'(r)) begin
              outVec[r*BITWIDTH +: BITWIDTH] <= resultHold;
            end
          end
          if (rowIdx == ROW_LAST) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            // rowAddr moves only here and on start, i.e. on entry to FETCH.
            rowIdx  <= rowIdx + 1'b1;
            rowAddr <= rowIdx + 1'b1;
            state   <= FETCH;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.rowAddr    = rowAddr;
  assign bus.prodWeight = prodWeight;
  assign bus.prodVec    = prodVec;
  assign bus.prodReset  = prodReset;
  assign bus.outVec     = outVec;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.error      = error;
endmodule

// File: tb/tb_matvec_sched.sv
// tb_matvec_sched
// Directed bench for matvec_sched: a registered weight memory and a
// behavioural array_prod stand-in with programmable latency (or a hang).
module tb_matvec_sched;
  localparam int NR  = 8;
  localparam int HS  = 8;
  localparam int BW  = 18;
  localparam int VW  = BW * HS;
  localparam int OW  = BW * NR;

  logic clock;
  logic reset;

  matvec_sched_if #(.NUM_ROWS(NR), .HIDDEN_SZ(HS), .BITWIDTH(BW), .ROW_ADDR_BITWIDTH(3)) bus ();

  matvec_sched dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cmpCnt = 0;
  int errCnt = 0;

  logic [VW-1:0] mem [NR];
  int            readyLat = 5;
  logic          stubHang = 1'b0;
  int            stubCnt = 0;

  always @(posedge clock) bus.weightRow <= mem[bus.rowAddr];

  always @(posedge clock) begin
    if (bus.prodReset) stubCnt <= 0;
    else               stubCnt <= stubCnt + 1;
  end

  function automatic logic [BW-1:0] dotQ(input logic [VW-1:0] v, input logic [VW-1:0] w);
    longint acc = 0;
    for (int j = 0; j < HS; j++)
      acc += longint'($signed(v[j*BW +: BW])) * longint'($signed(w[j*BW +: BW]));
    return BW'(acc >>> 11);
  endfunction

  assign bus.prodReady  = !bus.prodReset && !stubHang && (stubCnt == readyLat - 1);
  assign bus.prodResult = dotQ(bus.prodVec, bus.prodWeight);

  task automatic check(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
    cmpCnt++;
    assert (obs === exp) else begin
      errCnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starts one product (start held holdStart cycles) and follows it until
  // tail cycles after done, or a cycle budget runs out.
  task automatic runOne(input int holdStart, input int tail,
                        output int doneCyc, output int doneCnt, output int lowCyc,
                        output logic [23:0] addrSeq, output logic errAtFirst);
    logic prevReset;
    @(negedge clock);
    bus.start = 1'b1;
    doneCyc = -1; doneCnt = 0; lowCyc = 0; addrSeq = '1; errAtFirst = 1'bx;
    prevReset = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clock);
      if (k >= holdStart) bus.start = 1'b0;
      if (k == 1) errAtFirst = bus.error;
      if (!bus.prodReset && prevReset) addrSeq = {addrSeq[20:0], bus.rowAddr};
      prevReset = bus.prodReset;
      if (!bus.prodReset) lowCyc++;
      if (bus.done) begin
        doneCnt++;
        if (doneCyc < 0) doneCyc = k;
      end
      if (doneCyc >= 0 && k >= doneCyc + tail) break;
    end
    bus.start = 1'b0;
  endtask

  logic [VW-1:0] vecA, vecB;
  logic [OW-1:0] expA, expB, outSave;
  int            dc, dn, lc;
  logic [23:0]   aq;
  logic          ef;
  logic          err66, err67, busy67;

  initial begin
    for (int r = 0; r < NR; r++) mem[r] = {HS{BW'(512 * (r + 1))}};
    vecA = {HS{BW'(1024)}};
    for (int j = 0; j < HS; j++) vecB[j*BW +: BW] = (j % 2 == 0) ? BW'(2048) : BW'(-1024);
    // 0.5 * (r+1)*0.25 * 8 = (r+1)*1.0 ; alternating 1.0/-0.5 gives (r+1)*0.5
    for (int r = 0; r < NR; r++) begin
      expA[r*BW +: BW] = BW'(2048 * (r + 1));
      expB[r*BW +: BW] = BW'(1024 * (r + 1));
    end

    bus.start = 1'b0;
    bus.inVec = '0;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rst_rowAddr",    OW'(bus.rowAddr),    '0);
    check("rst_prodWeight", OW'(bus.prodWeight), '0);
    check("rst_prodVec",    OW'(bus.prodVec),    '0);
    check("rst_outVec",     bus.outVec,          '0);
    check("rst_prodReset",  OW'(bus.prodReset),  OW'(1));
    check("rst_busy",       OW'(bus.busy),       '0);
    check("rst_done",       OW'(bus.done),       '0);
    check("rst_error",      OW'(bus.error),      '0);

    // Basic product, L=5: done 8*(3+5)+1 = 65 cycles after start.
    bus.inVec = vecA; readyLat = 5;
    runOne(1, 3, dc, dn, lc, aq, ef);
    check("a_doneCyc", OW'(dc), OW'(65));
    check("a_doneCnt", OW'(dn), OW'(1));
    check("a_lowCyc",  OW'(lc), OW'(40));
    check("a_addrSeq", OW'(aq), OW'(24'o01234567));
    check("a_outVec",  bus.outVec, expA);
    check("a_prodVec", OW'(bus.prodVec), OW'(vecA));
    check("a_error",   OW'(bus.error), '0);
    check("a_busy",    OW'(bus.busy), '0);

    // start held 10 cycles, L=3: one product, done at 8*6+1 = 49.
    bus.inVec = vecB; readyLat = 3;
    runOne(10, 0, dc, dn, lc, aq, ef);
    check("b_doneCyc", OW'(dc), OW'(49));
    check("b_doneCnt", OW'(dn), OW'(1));
    check("b_outVec",  bus.outVec, expB);

    // Back-to-back: start in the first IDLE cycle after done, L=2 -> 41.
    bus.inVec = vecA; readyLat = 2;
    runOne(1, 3, dc, dn, lc, aq, ef);
    check("bb_doneCyc", OW'(dc), OW'(41));
    check("bb_doneCnt", OW'(dn), OW'(1));
    check("bb_outVec",  bus.outVec, expA);
    check("bb_lowCyc",  OW'(lc), OW'(16));

    // Watchdog: RUN cycles are k=3..66, IDLE with error at k=67.
    stubHang = 1'b1;
    outSave = bus.outVec;
    bus.inVec = vecB;
    @(negedge clock);
    bus.start = 1'b1;
    dn = 0; lc = 0; err66 = 1'bx; err67 = 1'bx; busy67 = 1'bx;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clock);
      bus.start = 1'b0;
      if (!bus.prodReset) lc++;
      if (bus.done) dn++;
      if (k == 66) err66 = bus.error;
      if (k == 67) begin err67 = bus.error; busy67 = bus.busy; end
    end
    check("to_err66",  OW'(err66), '0);
    check("to_err67",  OW'(err67), OW'(1));
    check("to_busy67", OW'(busy67), '0);
    check("to_doneCnt", OW'(dn), '0);
    check("to_lowCyc", OW'(lc), OW'(64));
    check("to_outKeep", bus.outVec, outSave);
    check("to_errHeld", OW'(bus.error), OW'(1));

    // Next start clears error; L=4 -> 8*7+1 = 57.
    stubHang = 1'b0; readyLat = 4;
    runOne(1, 3, dc, dn, lc, aq, ef);
    check("clr_errFirst", OW'(ef), '0);
    check("clr_doneCyc",  OW'(dc), OW'(57));
    check("clr_outVec",   bus.outVec, expB);

    // Reset during row 2 RUN (row r FETCH at k=1+8r, RUN from k=19).
    bus.inVec = vecA; readyLat = 5;
    @(negedge clock);
    bus.start = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock);
      bus.start = 1'b0;
      if (k == 19) begin
        check("mid_prodReset", OW'(bus.prodReset), '0);
        check("mid_rowAddr",   OW'(bus.rowAddr), OW'(2));
        reset = 1'b1;
      end
      if (k == 20) begin
        reset = 1'b0;
        check("mr_busy",      OW'(bus.busy), '0);
        check("mr_prodReset", OW'(bus.prodReset), OW'(1));
        check("mr_outVec",    bus.outVec, '0);
        check("mr_rowAddr",   OW'(bus.rowAddr), '0);
        check("mr_prodVec",   OW'(bus.prodVec), '0);
      end
    end

    bus.inVec = vecB; readyLat = 5;
    runOne(1, 3, dc, dn, lc, aq, ef);
    check("ar_doneCyc", OW'(dc), OW'(65));
    check("ar_outVec",  bus.outVec, expB);
    check("ar_addrSeq", OW'(aq), OW'(24'o01234567));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCnt, errCnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end
endmodule
